// File: rtl/fetch_target_queue.sv
// Fetch target queue: circular store of fetch-block start addresses tracked by
// commit/fetch/enqueue pointers carrying a wrap (flipped) bit above the index.
module fetch_target_queue #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 64,
    parameter int IDXW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_enq_vld,
    input  logic [XLEN-1:0] i_enq_startAddr,
    output logic            o_enq_rdy,
    output logic [IDXW:0]   o_enq_ftqIdx,
    output logic            o_fetch_vld,
    input  logic            i_fetch_rdy,
    output logic [XLEN-1:0] o_fetch_addr,
    output logic [IDXW:0]   o_fetch_ftqIdx,
    input  logic [IDXW-1:0] i_read_idx,
    output logic [XLEN-1:0] o_read_startAddr,
    input  logic            i_commit_vld,
    input  logic [IDXW:0]   i_commit_ftqIdx,
    input  logic            i_squash_vld,
    input  logic [IDXW:0]   i_squash_ftqIdx,
    output logic [IDXW:0]   o_count,
    output logic            o_empty,
    output logic            o_full
);

    typedef logic [IDXW:0] ptr_t;

    // Full-width increment: the idx field wraps into the flipped bit for free.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

    ptr_t            r_enq_ptr;
    ptr_t            r_fetch_ptr;
    ptr_t            r_commit_ptr;
    logic [XLEN-1:0] r_mem [DEPTH];

    ptr_t w_count;
    logic w_full;
    logic w_empty;
    logic w_enq_fire;
    logic w_fetch_vld;
    logic w_fetch_fire;
    ptr_t w_commit_ofs;
    ptr_t w_squash_ofs;

    assign w_count      = r_enq_ptr - r_commit_ptr;
    assign w_empty      = (r_enq_ptr == r_commit_ptr);
    assign w_full       = (r_enq_ptr[IDXW-1:0] == r_commit_ptr[IDXW-1:0]) &&
                          (r_enq_ptr[IDXW] != r_commit_ptr[IDXW]);
    assign w_enq_fire   = i_enq_vld && o_enq_rdy;
    assign w_fetch_vld  = (r_fetch_ptr != r_enq_ptr);
    assign w_fetch_fire = w_fetch_vld && i_fetch_rdy;
    assign w_commit_ofs = ptr_inc(i_commit_ftqIdx) - r_commit_ptr;
    assign w_squash_ofs = i_squash_ftqIdx - r_commit_ptr;

    assign o_enq_rdy        = !w_full && !i_squash_vld;
    assign o_enq_ftqIdx     = r_enq_ptr;
    assign o_fetch_vld      = w_fetch_vld;
    assign o_fetch_addr     = r_mem[r_fetch_ptr[IDXW-1:0]];
    assign o_fetch_ftqIdx   = r_fetch_ptr;
    assign o_read_startAddr = r_mem[i_read_idx];
    assign o_count          = w_count;
    assign o_empty          = w_empty;
    assign o_full           = w_full;

    // Squash rewinds both enq and fetch to just past the squashing block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enq_ptr    <= '0;
            r_fetch_ptr  <= '0;
            r_commit_ptr <= '0;
        end else begin
            if (i_squash_vld) begin
                r_enq_ptr   <= ptr_inc(i_squash_ftqIdx);
                r_fetch_ptr <= ptr_inc(i_squash_ftqIdx);
            end else begin
                if (w_enq_fire)
                    r_enq_ptr <= ptr_inc(r_enq_ptr);
                if (w_fetch_fire)
                    r_fetch_ptr <= ptr_inc(r_fetch_ptr);
            end
            if (i_commit_vld)
                r_commit_ptr <= ptr_inc(i_commit_ftqIdx);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq_fire)
            r_mem[r_enq_ptr[IDXW-1:0]] <= i_enq_startAddr;
    end

    // Offset zero on commit is a re-commit of the last retired block.
    a_commit_range: assert property (@(posedge clk) disable iff (rst)
        i_commit_vld |-> (w_commit_ofs <= w_count));
    a_squash_range: assert property (@(posedge clk) disable iff (rst)
        i_squash_vld |-> (w_squash_ofs < w_count));

endmodule

// File: tb/tb_fetch_target_queue.sv
// Randomized and directed bench for fetch_target_queue, using an
// unbounded-sequence-number reference model.
module tb_fetch_target_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int IDXW  = 2;
    localparam int PMOD  = 2 * DEPTH;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_enq_vld;
    logic [XLEN-1:0] i_enq_startAddr;
    logic            o_enq_rdy;
    logic [IDXW:0]   o_enq_ftqIdx;
    logic            o_fetch_vld;
    logic            i_fetch_rdy;
    logic [XLEN-1:0] o_fetch_addr;
    logic [IDXW:0]   o_fetch_ftqIdx;
    logic [IDXW-1:0] i_read_idx;
    logic [XLEN-1:0] o_read_startAddr;
    logic            i_commit_vld;
    logic [IDXW:0]   i_commit_ftqIdx;
    logic            i_squash_vld;
    logic [IDXW:0]   i_squash_ftqIdx;
    logic [IDXW:0]   o_count;
    logic            o_empty;
    logic            o_full;

    fetch_target_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst),
        .i_enq_vld(i_enq_vld), .i_enq_startAddr(i_enq_startAddr),
        .o_enq_rdy(o_enq_rdy), .o_enq_ftqIdx(o_enq_ftqIdx),
        .o_fetch_vld(o_fetch_vld), .i_fetch_rdy(i_fetch_rdy),
        .o_fetch_addr(o_fetch_addr), .o_fetch_ftqIdx(o_fetch_ftqIdx),
        .i_read_idx(i_read_idx), .o_read_startAddr(o_read_startAddr),
        .i_commit_vld(i_commit_vld), .i_commit_ftqIdx(i_commit_ftqIdx),
        .i_squash_vld(i_squash_vld), .i_squash_ftqIdx(i_squash_ftqIdx),
        .o_count(o_count), .o_empty(o_empty), .o_full(o_full)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: blocks are numbered by absolute sequence; pointers are counts.
    int              m_enq, m_fetch, m_commit;
    logic [XLEN-1:0] m_mem [DEPTH];
    bit              m_wr  [DEPTH];
    logic [XLEN-1:0] a_tab [4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model_clear();
        m_enq = 0; m_fetch = 0; m_commit = 0;
        for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
    endtask

    task automatic cycle(input bit ev, input logic [XLEN-1:0] a, input bit fr,
                         input bit cv, input int cabs, input bit sv, input int sabs,
                         input int ridx);
        bit exp_rdy, exp_fvld;
        i_enq_vld       = ev;
        i_enq_startAddr = a;
        i_fetch_rdy     = fr;
        i_commit_vld    = cv;
        i_commit_ftqIdx = 3'(cabs % PMOD);
        i_squash_vld    = sv;
        i_squash_ftqIdx = 3'(sabs % PMOD);
        i_read_idx      = 2'(ridx);
        #1;
        exp_rdy  = ((m_enq - m_commit) != DEPTH) && !sv;
        exp_fvld = (m_fetch != m_enq);
        chk("enq_rdy", 64'(o_enq_rdy), 64'(exp_rdy));
        chk("enq_idx", 64'(o_enq_ftqIdx), 64'(m_enq % PMOD));
        chk("count", 64'(o_count), 64'(m_enq - m_commit));
        chk("empty", 64'(o_empty), 64'(m_enq == m_commit));
        chk("full", 64'(o_full), 64'((m_enq - m_commit) == DEPTH));
        chk("fetch_vld", 64'(o_fetch_vld), 64'(exp_fvld));
        if (exp_fvld) begin
            chk("fetch_addr", o_fetch_addr, m_mem[m_fetch % DEPTH]);
            chk("fetch_idx", 64'(o_fetch_ftqIdx), 64'(m_fetch % PMOD));
        end
        if (m_wr[ridx]) chk("read_addr", o_read_startAddr, m_mem[ridx]);
        @(posedge clk);
        if (ev && exp_rdy) begin
            m_mem[m_enq % DEPTH] = a;
            m_wr[m_enq % DEPTH]  = 1'b1;
            m_enq++;
        end
        if (exp_fvld && fr) m_fetch++;
        if (cv) m_commit = cabs + 1;
        if (sv) begin
            m_enq   = sabs + 1;
            m_fetch = sabs + 1;
        end
        @(negedge clk);
        i_enq_vld = 0; i_fetch_rdy = 0; i_commit_vld = 0; i_squash_vld = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic fill4();
        for (int i = 0; i < 4; i++) cycle(1, a_tab[i], 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        a_tab[0] = 64'hA000_0000_0000_1000;
        a_tab[1] = 64'hA111_0000_0000_2040;
        a_tab[2] = 64'hA222_0000_0000_3080;
        a_tab[3] = 64'hA333_0000_0000_40C0;
        rst = 1'b1;
        i_enq_vld = 0; i_enq_startAddr = '0; i_fetch_rdy = 0; i_read_idx = '0;
        i_commit_vld = 0; i_commit_ftqIdx = '0; i_squash_vld = 0; i_squash_ftqIdx = '0;
        model_clear();
        #2;
        chk("rst_empty", 64'(o_empty), 64'd1);
        chk("rst_full", 64'(o_full), 64'd0);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_rdy", 64'(o_enq_rdy), 64'd1);
        chk("rst_fvld", 64'(o_fetch_vld), 64'd0);
        chk("rst_enqidx", 64'(o_enq_ftqIdx), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill to full, indices 0..3
        for (int i = 0; i < 4; i++) begin
            chk("fill_idx", 64'(o_enq_ftqIdx), 64'(i));
            cycle(1, a_tab[i], 0, 0, 0, 0, 0, i);
        end
        chk("fill_full", 64'(o_full), 64'd1);
        chk("fill_rdy", 64'(o_enq_rdy), 64'd0);
        chk("fill_count", 64'(o_count), 64'd4);

        // Drain fetch, commit 1, wrap-around enqueue
        for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0, 0, 0, 0, i);
        cycle(0, '0, 0, 1, 1, 0, 0, 0);
        chk("cmt_count", 64'(o_count), 64'd2);
        chk("wrap_idx0", 64'(o_enq_ftqIdx), 64'b100);
        cycle(1, 64'hB0, 0, 0, 0, 0, 0, 0);
        chk("wrap_idx1", 64'(o_enq_ftqIdx), 64'b101);
        cycle(1, 64'hB1, 0, 0, 0, 0, 0, 1);
        chk("wrap_full", 64'(o_full), 64'd1);

        // Squash idx 1 with enqueue attempt
        do_reset();
        fill4();
        cycle(1, 64'hDEAD, 0, 0, 0, 1, 1, 0);
        chk("sq_count", 64'(o_count), 64'd2);
        chk("sq_enqidx", 64'(o_enq_ftqIdx), 64'd2);
        chk("sq_fetchidx", 64'(o_fetch_ftqIdx), 64'd2);
        i_read_idx = 2'd1;
        #1 chk("sq_read1", o_read_startAddr, a_tab[1]);

        // Commit 0 together with squash 2
        do_reset();
        fill4();
        cycle(0, '0, 0, 1, 0, 1, 2, 0);
        chk("cs_count", 64'(o_count), 64'd2);
        chk("cs_enqidx", 64'(o_enq_ftqIdx), 64'd3);

        // Full plus commit plus enqueue: accepted only the cycle after
        do_reset();
        fill4();
        cycle(1, 64'hC0, 0, 1, 0, 0, 0, 0);
        chk("fc_count", 64'(o_count), 64'd3);
        chk("fc_enqidx", 64'(o_enq_ftqIdx), 64'b100);
        cycle(1, 64'hC0, 0, 0, 0, 0, 0, 0);
        chk("fc_count2", 64'(o_count), 64'd4);

        // Asynchronous reset between edges
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, a_tab[i], 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_empty", 64'(o_empty), 64'd1);
        chk("arst_fvld", 64'(o_fetch_vld), 64'd0);
        chk("arst_count", 64'(o_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();

        // Randomized legal traffic
        for (int n = 0; n < 3000; n++) begin
            bit ev, fr, cv, sv;
            int cabs, sabs, lo, slo;
            ev = ($urandom % 4) != 0;
            fr = ($urandom % 2) != 0;
            cv = 0; cabs = 0; sv = 0; sabs = 0;
            lo = (m_commit > 0) ? m_commit - 1 : 0;
            if (($urandom % 3) == 0 && m_fetch - 1 >= lo) begin
                cv   = 1;
                cabs = lo + int'($urandom % (m_fetch - lo));
            end
            slo = (cv && cabs > m_commit) ? cabs : m_commit;
            if (($urandom % 12) == 0 && m_enq - 1 >= slo) begin
                sv   = 1;
                sabs = slo + int'($urandom % (m_enq - slo));
            end
            cycle(ev, {$urandom, $urandom}, fr, cv, cabs, sv, sabs, int'($urandom % DEPTH));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
